vol_ctrl: RTL and testbench
===========================

Name: vol_ctrl

Overview:
Volume controller for the MP3 player. Turns raw up/down/mute buttons into a saturating volume level (attenuation steps, 0 = loudest, MAX_LEVEL = silent). Drives the LED bar's vol_level input. Schedules writes of the decoder SCI_VOL register through a req/ack handshake to the shared SCI writer, coalescing changes that arrive while a write is in flight.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized button must be stable before its debounced value changes
REPEAT_DELAY, 25000000, cycles of continuous hold before auto-repeat starts
REPEAT_PERIOD, 5000000, cycles between auto-repeat steps
MAX_LEVEL, 8, largest attenuation level (silent/LEDs dark)
DEFAULT_LEVEL, 4, level after reset
ATT_STEP, 16, SCI attenuation per level in 0.5 dB units; MAX_LEVEL*ATT_STEP must be <= 254

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_up  in  1  raw button, louder (level - 1)
btn_down  in  1  raw button, quieter (level + 1)
btn_mute  in  1  raw button, mute toggle
vol_level  out  5  displayed level to led_display; MAX_LEVEL while muted
muted  out  1  mute state
sci_req  out  1  write request to SCI writer
sci_addr  out  4  SCI register address, constant 4'hB (SCI_VOL)
sci_data  out  16  {att_left, att_right}
sci_ack  in  1  one-cycle pulse: SCI writer has accepted the write

Behaviour:
- Reset (async): level = DEFAULT_LEVEL, vol_level = DEFAULT_LEVEL, muted = 0, sci_req = 0, sci_data = 0, dirty = 1 (initial volume is always written), all debounce/repeat counters 0, FSM = IDLE.
- Each button: 2-FF synchronizer, then debouncer. Debounced value changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- Press event: one cycle on debounced 0->1 edge.
- Auto-repeat (up/down only): held for REPEAT_DELAY cycles after the press event -> step event, then one step every REPEAT_PERIOD while held. Release clears the repeat counter.
- Up and down both debounced-high: all up/down events ignored, repeat counters held at 0.
- Up step: level = max(level - 1, 0). Down step: level = min(level + 1, MAX_LEVEL). Saturated steps change nothing and do not set dirty.
- Mute press: toggles muted. Up/down event while muted: clears muted, level unchanged. Mute and up/down on the same cycle: mute wins, up/down dropped.
- vol_level = muted ? MAX_LEVEL : level, registered, updated the cycle after the event.
- Effective attenuation att (8 bits) = muted ? 8'hFE : level*ATT_STEP. Product computed at 8 bits. Any change of att sets dirty.
- SCI FSM:
  - IDLE: if dirty -> latch sci_data = {att, att}, sci_req = 1, clear dirty, go REQ.
  - REQ: sci_req and sci_data stay stable until sci_ack. On sci_ack: sci_req = 0, go IDLE. A new request can issue the next cycle if dirty.
  - att change during REQ sets dirty only; latched data is not altered. Multiple changes coalesce into one follow-up write carrying the latest att.
  - Same-cycle att change and entry to REQ: the latched data is the pre-change att, and dirty ends set.
  - sci_ack in IDLE: ignored.
- Reset mid-REQ: sci_req drops asynchronously; after release the initial write reissues.

Decomposition:
- Shared package mp3_pkg: SCI_VOL_ADDR = 4'hB, MUTE_ATT = 8'hFE, FSM state enum {IDLE, REQ}.
- One sub-module, btn_debounce (synchronizer, stability counter, press pulse, debounced level output), instantiated three times. Repeat logic and FSM stay in vol_ctrl.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset, ack each request 3 cycles after it rises -> vol_level=4, one write with sci_data=16'h4040, sci_addr=4'hB, then sci_req stays 0.
- btn_down with bounce (1,0,1 for 2 cycles each), then held 3 cycles -> no step; clean 6-cycle press -> vol_level=5, write 16'h5050.
- Hold btn_up 60 cycles from level 4 -> steps at press, +20, +28, +36 -> level 0; the +44 and +52 steps saturate, no further writes.
- Mute press at level 2 -> vol_level=8, muted=1, write 16'hFEFE. Then up press -> muted=0, vol_level=2, write 16'h2020.
- Hold sci_ack low while issuing 3 down presses during REQ -> first write data unchanged; after ack, exactly one further write with level+3 attenuation.
- up+down held together 40 cycles -> no level change, no write. Assert rst_n low during REQ -> sci_req=0 immediately, reissue 16'h4040 after release.

Source files
------------

// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 player control blocks.
package mp3_pkg;

    localparam logic [3:0] SCI_VOL_ADDR = 4'hB;
    localparam logic [7:0] MUTE_ATT     = 8'hFE;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sci_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, press pulse.
// The press pulse is high in the same cycle the debounced level first reads 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized input disagrees with the
    // debounced level; any agreeing cycle restarts the count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounced level and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/vol_ctrl.sv
// Volume controller: buttons -> saturating attenuation level, LED level
// output, and coalesced SCI_VOL writes through a req/ack handshake.
//
//   state | meaning
//   IDLE  | no write in flight; issue one when dirty
//   REQ   | sci_req high, sci_data frozen until sci_ack
module vol_ctrl
    import mp3_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int MAX_LEVEL       = 8,
    parameter int DEFAULT_LEVEL   = 4,
    parameter int ATT_STEP        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_mute,
    output logic [4:0]  vol_level,
    output logic        muted,
    output logic        sci_req,
    output logic [3:0]  sci_addr,
    output logic [15:0] sci_data,
    input  logic        sci_ack
);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
    localparam logic [4:0] MAX_LVL = 5'(MAX_LEVEL);
    localparam logic [4:0] DEF_LVL = 5'(DEFAULT_LEVEL);

    function automatic logic [7:0] att_of(input logic m, input logic [4:0] lvl);
        return m ? MUTE_ATT : 8'(int'(lvl) * ATT_STEP);
    endfunction

    logic [1:0] lvl_ud, press_ud, held, step;
    logic       mute_lvl, mute_press, both;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_up),
        .btn_level(lvl_ud[0]), .btn_press(press_ud[0]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_down),
        .btn_level(lvl_ud[1]), .btn_press(press_ud[1]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mute (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_mute),
        .btn_level(mute_lvl), .btn_press(mute_press));

    assign both = lvl_ud[0] & lvl_ud[1];
    assign held = both ? 2'b00 : lvl_ud;

    logic [1:0][REP_W-1:0] rep_q, rep_d;
    logic [4:0]            level_q, level_d;
    logic                  muted_q, muted_d;
    logic [4:0]            vol_level_q, vol_level_d;
    logic [7:0]            att_cur, att_nxt;
    logic                  att_chg;

    // Auto-repeat down-timers: press loads the delay, terminal count steps
    // and reloads the period; release or both-held parks the timer at 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_d[i] = '0;
            step[i]  = 1'b0;
            if (held[i]) begin
                if (press_ud[i]) begin
                    rep_d[i] = REP_DLY;
                    step[i]  = 1'b1;
                end else if (rep_q[i] == REP_ONE) begin
                    rep_d[i] = REP_PER;
                    step[i]  = 1'b1;
                end else if (rep_q[i] != '0) begin
                    rep_d[i] = rep_q[i] - 1'b1;
                end
            end
        end
    end

    // Level and mute update; mute beats a same-cycle up/down step.
    always_comb begin
        level_d = level_q;
        muted_d = muted_q;
        if (mute_press) begin
            muted_d = ~muted_q;
        end else if (step != 2'b00) begin
            if (muted_q) begin
                muted_d = 1'b0;
            end else if (step[0] && level_q != 5'd0) begin
                level_d = level_q - 5'd1;
            end else if (step[1] && level_q != MAX_LVL) begin
                level_d = level_q + 5'd1;
            end
        end
        vol_level_d = muted_d ? MAX_LVL : level_d;
        att_cur     = att_of(muted_q, level_q);
        att_nxt     = att_of(muted_d, level_d);
        att_chg     = (att_cur != att_nxt);
    end

    // Level, mute, display and repeat-timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q       <= '0;
            level_q     <= DEF_LVL;
            muted_q     <= 1'b0;
            vol_level_q <= DEF_LVL;
        end else begin
            rep_q       <= rep_d;
            level_q     <= level_d;
            muted_q     <= muted_d;
            vol_level_q <= vol_level_d;
        end
    end

    sci_state_e  state_q, state_d;
    logic        dirty_q, dirty_d;
    logic [15:0] sci_data_q, sci_data_d;

    // SCI write FSM. The latch captures the pre-change att, so a change in
    // the issuing cycle leaves dirty set for a follow-up write.
    always_comb begin
        state_d    = state_q;
        dirty_d    = dirty_q | att_chg;
        sci_data_d = sci_data_q;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    sci_data_d = {att_cur, att_cur};
                    dirty_d    = att_chg;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (sci_ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // SCI FSM state register; dirty resets high so the initial volume is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dirty_q    <= 1'b1;
            sci_data_q <= '0;
        end else begin
            state_q    <= state_d;
            dirty_q    <= dirty_d;
            sci_data_q <= sci_data_d;
        end
    end

    assign vol_level = vol_level_q;
    assign muted     = muted_q;
    assign sci_req   = (state_q == REQ);
    assign sci_addr  = SCI_VOL_ADDR;
    assign sci_data  = sci_data_q;

endmodule

// File: tb/tb_vol_ctrl.sv
// Bench for vol_ctrl: directed scenarios plus randomized button activity,
// checked every cycle against a behavioural model of the button/volume rules.
module tb_vol_ctrl;
    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MAXL = 8;
    localparam int DEFL = 4;
    localparam int STEP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_mute = 1'b0;
    logic        sci_ack = 1'b0;
    logic [4:0]  vol_level;
    logic        muted, sci_req;
    logic [3:0]  sci_addr;
    logic [15:0] sci_data;

    always #5 clk = ~clk;

    vol_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .MAX_LEVEL(MAXL), .DEFAULT_LEVEL(DEFL), .ATT_STEP(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_mute(btn_mute), .vol_level(vol_level), .muted(muted),
        .sci_req(sci_req), .sci_addr(sci_addr), .sci_data(sci_data),
        .sci_ack(sci_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    bit ack_en = 1'b1;
    bit stray_en = 1'b0;
    int ack_dly = 3;
    logic [15:0] wr_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_level = DEFL;
    bit   m_muted, m_busy, m_dirty;
    logic [15:0] m_data;
    bit   m_deb[3], m_press[3], m_d1[3], m_d2[3];
    bit   m_win[3][DEB];
    bit   m_act[2];
    int   m_age[2];

    function automatic logic [7:0] f_att(input bit mu, input int lvl);
        return mu ? 8'hFE : 8'(lvl * STEP);
    endfunction

    initial begin : model
        bit ev[2];
        bit raw[3];
        bit held, all_diff, mute_ev;
        logic [7:0] a_old, a_new;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_level = DEFL; m_muted = 0; m_busy = 0; m_dirty = 1; m_data = 16'h0;
                for (int i = 0; i < 3; i++) begin
                    m_deb[i] = 0; m_press[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
                    for (int j = 0; j < DEB; j++) m_win[i][j] = 0;
                end
                for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_age[i] = 0; end
            end else begin
                // button events as seen from the debounced state of the previous cycle
                for (int i = 0; i < 2; i++) begin
                    ev[i] = 0;
                    held = m_deb[i] && !m_deb[1-i];
                    if (!held) m_act[i] = 0;
                    else if (m_press[i]) begin m_act[i] = 1; m_age[i] = 0; ev[i] = 1; end
                    else if (m_act[i]) begin
                        m_age[i]++;
                        if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) ev[i] = 1;
                    end
                end
                mute_ev = m_press[2];
                a_old = f_att(m_muted, m_level);
                if (mute_ev) m_muted = !m_muted;
                else if (ev[0] || ev[1]) begin
                    if (m_muted) m_muted = 0;
                    else if (ev[0]) m_level = (m_level > 0) ? m_level - 1 : 0;
                    else m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
                end
                a_new = f_att(m_muted, m_level);
                if (m_busy) begin
                    if (sci_ack) m_busy = 0;
                    m_dirty = m_dirty || (a_new != a_old);
                end else if (m_dirty) begin
                    m_data  = {a_old, a_old};
                    m_busy  = 1;
                    m_dirty = (a_new != a_old);
                end else begin
                    m_dirty = (a_new != a_old);
                end
                // debounce: level flips once the last DEB synchronized samples all disagree
                raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_mute;
                for (int i = 0; i < 3; i++) begin
                    for (int j = DEB - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
                    m_win[i][0] = m_d2[i];
                    all_diff = 1;
                    for (int j = 0; j < DEB; j++) if (m_win[i][j] == m_deb[i]) all_diff = 0;
                    m_press[i] = 0;
                    if (all_diff) begin m_deb[i] = !m_deb[i]; m_press[i] = m_deb[i]; end
                    m_d2[i] = m_d1[i];
                    m_d1[i] = raw[i];
                end
            end
        end
    end

    // compare DUT against the model on every falling edge
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("vol_level", 32'(vol_level), 32'(m_muted ? MAXL : m_level));
                check("muted", 32'(muted), 32'(m_muted));
                check("sci_req", 32'(sci_req), 32'(m_busy));
                check("sci_data", 32'(sci_data), 32'(m_data));
                check("sci_addr", 32'(sci_addr), 32'hB);
            end
        end
    end

    // accepted writes
    initial begin : capture
        forever begin
            @(posedge clk);
            if (rst_n && sci_req && sci_ack) wr_log.push_back(sci_data);
        end
    end

    // SCI writer: ack ack_dly cycles into each request, optional stray acks in idle
    initial begin : acker
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            sci_ack = 1'b0;
            if (sci_req && ack_en) begin
                cnt++;
                if (cnt >= ack_dly) begin sci_ack = 1'b1; cnt = 0; end
            end else begin
                cnt = 0;
                if (!sci_req && stray_en && $urandom_range(9) == 0) sci_ack = 1'b1;
            end
        end
    end

    task automatic drive(input logic [2:0] v);
        {btn_mute, btn_down, btn_up} = v;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] v, input int hold, input int gap);
        drive(v); cyc(hold); drive(3'b000); cyc(gap);
    endtask

    initial begin : stim
        int base;
        logic [2:0] pat[8];
        #1 rst_n = 1'b0;
        cyc(3);
        chk_on = 1'b1;
        rst_n = 1'b1;
        // initial write
        cyc(12);
        check("init_writes", 32'(wr_log.size()), 1);
        if (wr_log.size() > 0) check("init_data", 32'(wr_log[0]), 32'h4040);
        check("init_vol", 32'(vol_level), 4);
        check("init_req_idle", 32'(sci_req), 0);
        // bounce never stable for DEB cycles
        pat = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
        foreach (pat[k]) begin drive(pat[k]); cyc(1); end
        cyc(15);
        check("bounce_vol", 32'(vol_level), 4);
        check("bounce_writes", 32'(wr_log.size()), 1);
        press(3'b010, 6, 15);
        check("down_vol", 32'(vol_level), 5);
        check("down_data", 32'(wr_log[$]), 32'h5050);
        // back to 4, then hold up with auto-repeat into saturation
        press(3'b001, 6, 15);
        base = wr_log.size();
        press(3'b001, 60, 20);
        check("hold_vol", 32'(vol_level), 0);
        check("hold_writes", 32'(wr_log.size() - base), 4);
        check("hold_last", 32'(wr_log[$]), 32'h0000);
        // mute at level 2, then unmute with up
        press(3'b010, 6, 15);
        press(3'b010, 6, 15);
        press(3'b100, 6, 15);
        check("mute_vol", 32'(vol_level), 8);
        check("mute_flag", 32'(muted), 1);
        check("mute_data", 32'(wr_log[$]), 32'hFEFE);
        press(3'b001, 6, 15);
        check("unmute_vol", 32'(vol_level), 2);
        check("unmute_flag", 32'(muted), 0);
        check("unmute_data", 32'(wr_log[$]), 32'h2020);
        // coalescing while a write is stalled
        ack_en = 1'b0;
        base = wr_log.size();
        press(3'b010, 6, 10);
        repeat (3) press(3'b010, 6, 10);
        check("stall_req", 32'(sci_req), 1);
        check("stall_data", 32'(sci_data), 32'h3030);
        check("stall_vol", 32'(vol_level), 6);
        ack_en = 1'b1;
        cyc(20);
        check("coal_writes", 32'(wr_log.size() - base), 2);
        check("coal_first", 32'(wr_log[base]), 32'h3030);
        check("coal_last", 32'(wr_log[$]), 32'h6060);
        // up+down together
        base = wr_log.size();
        press(3'b011, 40, 20);
        check("both_vol", 32'(vol_level), 6);
        check("both_writes", 32'(wr_log.size() - base), 0);
        // reset during a stalled request
        ack_en = 1'b0;
        press(3'b001, 6, 15);
        check("pre_rst_req", 32'(sci_req), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_req_async", 32'(sci_req), 0);
        check("rst_vol_async", 32'(vol_level), 4);
        cyc(2);
        rst_n = 1'b1;
        ack_en = 1'b1;
        base = wr_log.size();
        cyc(12);
        check("rst_reissue_cnt", 32'(wr_log.size() - base), 1);
        check("rst_reissue", 32'(wr_log[$]), 32'h4040);
        // randomized activity with bounce glitches, random ack latency, stray acks
        stray_en = 1'b1;
        for (int it = 0; it < 60; it++) begin
            logic [2:0] mask;
            int hold;
            mask = 3'($urandom_range(7, 1));
            hold = $urandom_range(70);
            ack_dly = $urandom_range(5, 1);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(11) == 0) drive(mask ^ 3'($urandom_range(7)));
                else drive(mask);
                cyc(1);
            end
            drive(3'b000);
            cyc($urandom_range(30));
        end
        stray_en = 1'b0;
        ack_en = 1'b1;
        cyc(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
